// File: rtl/dadda_acc_stage.sv
// Frame accumulator behind the 32x32 Dadda multiplier: sums a frame of 64-bit
// products and holds the result on a valid/ready handshake until drained.
module dadda_acc_stage #(
    parameter int ACC_W = 72,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [63:0]      in_prod,
    input  logic             in_valid,
    input  logic             in_last,
    output logic             in_ready,
    output logic [ACC_W-1:0] out_acc,
    output logic [CNT_W-1:0] out_count,
    output logic             out_ovf,
    output logic             out_valid,
    input  logic             out_ready
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ovf_q, ovf_d;

    logic               accept;
    logic [ACC_W-1:0]   prod_ext;
    logic [ACC_W:0]     sum;
    logic [CNT_W:0]     cnt_inc;

    // Returns {clamped, value}: clamped is set when the counter is already at max.
    function automatic logic [CNT_W:0] sat_inc(input logic [CNT_W-1:0] c);
        if (&c)
            return {1'b1, c};
        else
            return {1'b0, c + CNT_W'(1)};
    endfunction

    assign accept   = in_valid & in_ready;
    assign prod_ext = ACC_W'(in_prod);
    assign sum      = {1'b0, acc_q} + {1'b0, prod_ext};
    assign cnt_inc  = sat_inc(cnt_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_ACCUM: begin
                if (accept)
                    state_d = in_last ? S_HOLD : S_ACCUM;
            end
            S_HOLD: begin
                // A beat arriving with the drain opens the next frame without a bubble.
                if (out_ready) begin
                    if (in_valid)
                        state_d = in_last ? S_HOLD : S_ACCUM;
                    else
                        state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        acc_d = acc_q;
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        if (accept) begin
            if (state_q != S_ACCUM) begin
                acc_d = prod_ext;
                cnt_d = CNT_W'(1);
                ovf_d = 1'b0;
            end else begin
                acc_d = sum[ACC_W-1:0];
                cnt_d = cnt_inc[CNT_W-1:0];
                ovf_d = ovf_q | sum[ACC_W] | cnt_inc[CNT_W];
            end
        end
    end

    always_comb begin
        in_ready  = (state_q != S_HOLD) | out_ready;
        out_valid = (state_q == S_HOLD);
        out_acc   = acc_q;
        out_count = cnt_q;
        out_ovf   = ovf_q;
    end

endmodule

// File: tb/tb_dadda_acc_stage.sv
// Directed bench for dadda_acc_stage: a frame-level reference model checked every
// cycle, plus literal expectations on each drained frame result.
module tb_dadda_acc_stage;

    localparam int ACC_W = 72;
    localparam int CNT_W = 16;
    localparam logic [63:0] PMAX = 64'hFFFF_FFFF_FFFF_FFFF;

    logic             clk;
    logic             rst;
    logic [63:0]      in_prod;
    logic             in_valid;
    logic             in_last;
    logic             in_ready;
    logic [ACC_W-1:0] out_acc;
    logic [CNT_W-1:0] out_count;
    logic             out_ovf;
    logic             out_valid;
    logic             out_ready;

    int checks   = 0;
    int failures = 0;

    dadda_acc_stage #(.ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_prod   (in_prod),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_acc   (out_acc),
        .out_count (out_count),
        .out_ovf   (out_ovf),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: exact frame sum in wide arithmetic, one pending result slot.
    logic             model_live = 1'b0;
    logic [127:0]     fsum = '0;
    int               fcnt = 0;
    logic             pend_v = 1'b0;
    logic [ACC_W-1:0] pend_acc = '0;
    logic [CNT_W-1:0] pend_cnt = '0;
    logic             pend_ovf = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            model_live = 1'b1;
            pend_v     = 1'b0;
            fsum       = '0;
            fcnt       = 0;
        end else if (model_live) begin
            logic acc_ok;
            acc_ok = in_valid && (!pend_v || out_ready);
            if (pend_v && out_ready)
                pend_v = 1'b0;
            if (acc_ok) begin
                fsum = fsum + {64'd0, in_prod};
                fcnt = fcnt + 1;
                if (in_last) begin
                    pend_acc = fsum[ACC_W-1:0];
                    pend_cnt = (fcnt > 65535) ? 16'hFFFF : 16'(fcnt);
                    pend_ovf = ((fsum >> ACC_W) != 0) || (fcnt > 65535);
                    pend_v   = 1'b1;
                    fsum     = '0;
                    fcnt     = 0;
                end
            end
        end
    end

    // Drained results, kept for the literal checks in the stimulus process.
    logic [ACC_W-1:0] log_acc[$];
    logic [CNT_W-1:0] log_cnt[$];
    logic             log_ovf[$];

    always @(negedge clk) begin
        if (model_live) begin
            check("in_ready", 128'(in_ready), 128'(!pend_v || out_ready));
            check("out_valid", 128'(out_valid), 128'(pend_v));
            if (pend_v) begin
                check("out_acc", 128'(out_acc), 128'(pend_acc));
                check("out_count", 128'(out_count), 128'(pend_cnt));
                check("out_ovf", 128'(out_ovf), 128'(pend_ovf));
            end
            if (out_valid && out_ready && !rst) begin
                log_acc.push_back(out_acc);
                log_cnt.push_back(out_count);
                log_ovf.push_back(out_ovf);
            end
        end
    end

    task automatic drive(input logic [63:0] p, input logic v, input logic l, input logic r);
        in_prod   = p;
        in_valid  = v;
        in_last   = l;
        out_ready = r;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            drive(64'd0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic reset_cycle();
        rst      = 1'b1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic expect_log(input string name, input logic [ACC_W-1:0] acc,
                              input logic [CNT_W-1:0] cnt, input logic ovf);
        check({name, "_present"}, 128'(log_acc.size() > 0), 128'(1));
        if (log_acc.size() > 0) begin
            check({name, "_acc"}, 128'(log_acc.pop_front()), 128'(acc));
            check({name, "_count"}, 128'(log_cnt.pop_front()), 128'(cnt));
            check({name, "_ovf"}, 128'(log_ovf.pop_front()), 128'(ovf));
        end
    endtask

    initial begin
        rst       = 1'b1;
        in_prod   = '0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_acc", 128'(out_acc), 128'(0));
        check("rst_count", 128'(out_count), 128'(0));
        check("rst_ovf", 128'(out_ovf), 128'(0));
        check("rst_out_valid", 128'(out_valid), 128'(0));
        check("rst_in_ready", 128'(in_ready), 128'(1));

        // Four-beat frame
        drive(64'd1, 1, 0, 1);
        drive(64'd2, 1, 0, 1);
        drive(64'd3, 1, 0, 1);
        drive(64'd4, 1, 1, 1);
        check("t1_valid_after_last", 128'(out_valid), 128'(1));
        idle(3);
        expect_log("t1", 72'd10, 16'd4, 1'b0);
        check("t1_one_result", 128'(log_acc.size()), 128'(0));

        // Single-beat frame held under backpressure
        drive(PMAX, 1, 1, 0);
        for (int i = 0; i < 5; i++)
            drive(64'h123, 1, 0, 0);
        check("t2_hold_in_ready", 128'(in_ready), 128'(0));
        check("t2_hold_valid", 128'(out_valid), 128'(1));
        check("t2_hold_acc", 128'(out_acc), 128'(72'h00_FFFF_FFFF_FFFF_FFFF));
        drive(64'd0, 0, 0, 1);
        check("t2_drained", 128'(out_valid), 128'(0));
        idle(2);
        expect_log("t2", 72'h00_FFFF_FFFF_FFFF_FFFF, 16'd1, 1'b0);

        // 256 max products fit; 257 overflow the accumulator
        for (int i = 0; i < 256; i++)
            drive(PMAX, 1, (i == 255), 1);
        idle(2);
        expect_log("t3_256", 72'hFF_FFFF_FFFF_FFFF_FF00, 16'd256, 1'b0);
        for (int i = 0; i < 257; i++)
            drive(PMAX, 1, (i == 256), 1);
        idle(2);
        expect_log("t3_257", 72'h00_FFFF_FFFF_FFFF_FEFF, 16'd257, 1'b1);

        // Back-to-back frames with no bubble
        drive(64'd5, 1, 0, 1);
        drive(64'd7, 1, 1, 1);
        check("t4_ready_mid", 128'(in_ready), 128'(1));
        drive(64'd9, 1, 1, 1);
        check("t4_second_valid", 128'(out_valid), 128'(1));
        idle(2);
        expect_log("t4_a", 72'd12, 16'd2, 1'b0);
        expect_log("t4_b", 72'd9, 16'd1, 1'b0);

        // Gaps, including in_last with in_valid low
        drive(64'd6, 1, 0, 1);
        drive(64'd99, 0, 1, 1);
        check("t5_gap_no_close", 128'(out_valid), 128'(0));
        drive(64'd99, 0, 0, 1);
        drive(64'd8, 1, 1, 1);
        idle(2);
        expect_log("t5", 72'd14, 16'd2, 1'b0);

        // Reset mid-frame and during hold discards the result
        drive(64'd1, 1, 0, 1);
        drive(64'd2, 1, 0, 1);
        drive(64'd3, 1, 0, 1);
        reset_cycle();
        check("t6_accum_rst_valid", 128'(out_valid), 128'(0));
        check("t6_accum_rst_ready", 128'(in_ready), 128'(1));
        drive(64'd50, 1, 1, 0);
        drive(64'd0, 0, 0, 0);
        check("t6_in_hold", 128'(out_valid), 128'(1));
        reset_cycle();
        check("t6_hold_rst_valid", 128'(out_valid), 128'(0));
        check("t6_hold_rst_ready", 128'(in_ready), 128'(1));
        drive(64'd11, 1, 1, 1);
        idle(2);
        expect_log("t6", 72'd11, 16'd1, 1'b0);
        check("t6_no_stray_result", 128'(log_acc.size()), 128'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dadda_acc_stage.md
Name: dadda_acc_stage

Overview:
- Downstream consumer of the 64-bit unsigned product from the 32x32 Dadda multiplier.
- Accumulates a frame of products (a dot product) into a wide register and closes the frame on in_last.
- Presents the frame result on a valid/ready output handshake.
- Gives the purely combinational multiplier a registered, flow-controlled result path into the rest of the datapath.

Parameters:
ACC_W, 72, accumulator width in bits; must be >= 64 (default absorbs 256 max-value products without overflow)
CNT_W, 16, width of the per-frame product counter

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
in_prod  input  64  unsigned product from multiplier Y output
in_valid  input  1  in_prod/in_last valid this cycle
in_last  input  1  accepted beat is the final product of the frame
in_ready  output  1  stage can accept a beat this cycle
out_acc  output  ACC_W  frame sum, modulo 2^ACC_W
out_count  output  CNT_W  number of products in frame (saturating)
out_ovf  output  1  sticky: frame sum exceeded ACC_W bits or counter saturated
out_valid  output  1  frame result available
out_ready  input  1  downstream accepts result

Behaviour:
- Clock/reset: one clock, clk. Reset is rst, synchronous and active-high.
- Reset:
  - state=IDLE, acc=0, count=0, ovf=0.
  - out_valid=0, in_ready=1 in the first cycle after reset.
  - rst mid-frame or during HOLD discards the partial or held result with no output.
- Accept: a beat is accepted when in_valid & in_ready.
- Drain: a result is taken when out_valid & out_ready.
- in_ready = (state != HOLD) | out_ready. The combinational path from out_ready to in_ready is intended.
- out_valid = (state == HOLD), registered.
- out_acc, out_count and out_ovf are the registers acc, count and ovf.
  - In HOLD they are stable until drained.
  - Outside HOLD their values are don't-care for consumers.
- State IDLE (no frame open):
  - Accept with in_last=0 -> ACCUM, acc=zext(in_prod), count=1, ovf=0.
  - Accept with in_last=1 -> HOLD, same loads (single-beat frame).
- State ACCUM:
  - Accept -> acc = acc + zext(in_prod). Carry out of bit ACC_W-1 sets ovf; acc wraps.
  - Count increments, saturating at 2^CNT_W-1; saturation sets ovf.
  - in_last=1 -> HOLD, else stay ACCUM.
  - No accept -> hold all state.
- State HOLD:
  - Drain without accept -> IDLE.
  - Drain with a simultaneous accept -> the beat opens a new frame (loads as in IDLE) and moves to ACCUM, or to HOLD if in_last=1. No bubble.
  - No drain -> hold everything and in_ready=0; in_valid is ignored.
- Latency: the result is visible (out_valid=1) in the cycle after the in_last beat is accepted.
- Throughput: one product per cycle; back-to-back frames sustain full rate when out_ready=1.
- Additions are unsigned. in_prod is zero-extended to ACC_W; no sign handling.
- in_last with in_valid=0 is ignored.

Test Plan:
1. Reset, then frame of 4 beats: in_prod=1,2,3,4 with in_last on the 4th, out_ready=1 -> out_valid for exactly 1 cycle, out_acc=10, out_count=4, out_ovf=0; the following cycle out_valid=0, in_ready=1.
2. Single-beat frame in_prod=64'hFFFF_FFFF_FFFF_FFFF, in_last=1, out_ready=0 for 5 cycles -> out_valid held, out_acc=2^64-1, in_ready=0 and in_valid ignored; then out_ready=1 -> drained, state IDLE.
3. 256 beats of 2^64-1 then a 257th -> out_acc=(257*(2^64-1)) mod 2^72, out_ovf=1, out_count=257; with 256 beats only, out_ovf=0 and out_acc=256*(2^64-1).
4. Back-to-back frames: frame A (5,7, last), frame B (9, last) presented in consecutive cycles with out_ready=1 -> in_ready stays 1, results 12 then 9 on consecutive out_valid cycles, no bubble.
5. Gaps: in_valid toggling 1,0,0,1(last) with prods 6,x,x,8 -> out_acc=14, out_count=2; in_last with in_valid=0 does not close the frame.
6. rst asserted mid-ACCUM after 3 beats, and again during HOLD -> next cycle out_valid=0, in_ready=1; a following frame (11, last) yields out_acc=11, out_count=1.
